// File: rtl/alu_op_controller.sv
// alu_op_controller: sequences one ALU operation at a time.
// - Latches the opcode and operands onto the ALU ports when a request is accepted.
// - Times multi-cycle divide and multiply operations with a 6-bit down-counter.
// - Captures the 64-bit ALU result and pulses done.
// - Illegal opcodes are answered immediately with done and err.
// Optional feature: define ALU_OP_CONTROLLER_DIV0_TRAP_EN to reject a divide
// by zero with err instead of running it through the divider.
module alu_op_controller #(
  parameter int unsigned DIV_LATENCY = 34,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        ready,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_ra,
  output logic [31:0] alu_rb,
  output logic        div_start,
  input  logic [63:0] alu_rz,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        done,
  output logic        err
);

  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 1);
  localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [31:0] ra_q, ra_d;
  logic [31:0] rb_q, rb_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        dstart_q, dstart_d;
  logic        div0_trap_s;

  // Opcodes the ALU implements; 01010 and 01110..11111 are holes in the encoding.
  function automatic logic op_legal(input logic [4:0] o);
    logic ok;
    case (o)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
      5'b01011, 5'b01100, 5'b01101: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef ALU_OP_CONTROLLER_DIV0_TRAP_EN
  assign div0_trap_s = (op == OP_DIV) && (b_in == 32'd0);
`else
  assign div0_trap_s = 1'b0;
`endif

  assign ready      = (state_q == S_IDLE) || (state_q == S_DONE);
  assign alu_opcode = opcode_q;
  assign alu_ra     = ra_q;
  assign alu_rb     = rb_q;
  assign result_lo  = lo_q;
  assign result_hi  = hi_q;
  assign done       = done_q;
  assign err        = err_q;
  assign div_start  = dstart_q;

  // Next-state logic: accept requests, count down EXEC, capture the result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    dstart_d = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (cnt_q == 6'd0) begin
          lo_d    = alu_rz[31:0];
          hi_d    = alu_rz[63:32];
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          opcode_d = op;
          ra_d     = a_in;
          rb_d     = b_in;
          if (!op_legal(op) || div0_trap_s) begin
            // Rejected request: report at once, leave the results untouched.
            state_d = S_DONE;
            cnt_d   = 6'd0;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = S_EXEC;
            dstart_d = (op == OP_DIV);
            if (op == OP_DIV) begin
              cnt_d = DIV_CNT;
            end else if (op == OP_MUL) begin
              cnt_d = MUL_CNT;
            end else begin
              cnt_d = 6'd0;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      opcode_q <= 5'd0;
      ra_q     <= 32'd0;
      rb_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_q     <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dstart_q <= dstart_d;
    end
  end

endmodule

// File: tb/tb_alu_op_controller.sv
// Self-checking bench for alu_op_controller with an ALU stub and a
// transaction-level reference model.
module tb_alu_op_controller;

  localparam int DIV_LAT = 34;
  localparam int MUL_LAT = 1;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, MUL = 5'b00010, DIV = 5'b00011;
  localparam logic [4:0] AND_ = 5'b00100, OR_ = 5'b00101, SHRA = 5'b00111;
  localparam logic [4:0] ROR = 5'b01001, ROL = 5'b01011, BAD = 5'b01010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op = 5'd0;
  logic [31:0] a_in = 32'd0, b_in = 32'd0;
  logic        ready, div_start, done, err;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_ra, alu_rb, result_lo, result_hi;
  logic [63:0] alu_rz;

  int n_checks = 0;
  int n_err = 0;
  logic check_en = 1'b1;

  alu_op_controller #(.DIV_LATENCY(DIV_LAT), .MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .ready(ready), .alu_opcode(alu_opcode), .alu_ra(alu_ra), .alu_rb(alu_rb),
    .div_start(div_start), .alu_rz(alu_rz), .result_lo(result_lo),
    .result_hi(result_hi), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each opcode: {hi, lo}.
  function automatic logic [63:0] alu_ref(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  s;
    logic [31:0] t;
    s = b[4:0];
    case (o)
      5'b00000: return {32'h0, a + b};
      5'b00001: return {32'h0, a - b};
      5'b00010: return {32'h0, a} * {32'h0, b};
      5'b00011: return (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      5'b00100: return {32'h0, a & b};
      5'b00101: return {32'h0, a | b};
      5'b00110: return {32'h0, a >> s};
      5'b00111: begin t = $unsigned($signed(a) >>> s); return {32'h0, t}; end
      5'b01000: return {32'h0, a << s};
      5'b01001: begin t = (s == 5'd0) ? a : ((a >> s) | (a << (6'd32 - {1'b0, s}))); return {32'h0, t}; end
      5'b01011: begin t = (s == 5'd0) ? a : ((a << s) | (a >> (6'd32 - {1'b0, s}))); return {32'h0, t}; end
      5'b01100: return {32'h0, -a};
      5'b01101: return {32'h0, ~a};
      default:  return 64'h0;
    endcase
  endfunction

  // ALU stub feeding the controller.
  always_comb alu_rz = alu_ref(alu_opcode, alu_ra, alu_rb);

  // Reference model: a request occupies the controller for a number of EXEC cycles.
  int          m_busy = 0;
  logic        m_done = 1'b0, m_err = 1'b0, m_ds = 1'b0;
  logic [4:0]  m_op = 5'd0;
  logic [31:0] m_ra = 32'd0, m_rb = 32'd0, m_lo = 32'd0, m_hi = 32'd0;
  logic [63:0] m_r;
  logic        m_reject;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_done = 1'b0; m_err = 1'b0; m_ds = 1'b0;
      m_op = 5'd0; m_ra = 32'd0; m_rb = 32'd0; m_lo = 32'd0; m_hi = 32'd0;
    end else begin
      m_done = 1'b0; m_err = 1'b0; m_ds = 1'b0;
      if (m_busy > 0) begin
        m_busy = m_busy - 1;
        if (m_busy == 0) begin
          m_r = alu_ref(m_op, m_ra, m_rb);
          m_lo = m_r[31:0]; m_hi = m_r[63:32]; m_done = 1'b1;
        end
      end else if (start) begin
        m_op = op; m_ra = a_in; m_rb = b_in;
        m_reject = (op == 5'd10) || (op >= 5'd14);
`ifdef ALU_OP_CONTROLLER_DIV0_TRAP_EN
        if (op == DIV && b_in == 32'd0) m_reject = 1'b1;
`endif
        if (m_reject) begin
          m_done = 1'b1; m_err = 1'b1;
        end else begin
          m_busy = (op == DIV) ? DIV_LAT : (op == MUL) ? MUL_LAT : 1;
          m_ds = (op == DIV);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_ready", {63'd0, ready}, {63'd0, m_busy == 0});
      chk("m_done", {63'd0, done}, {63'd0, m_done});
      chk("m_err", {63'd0, err}, {63'd0, m_err});
      chk("m_div_start", {63'd0, div_start}, {63'd0, m_ds});
      chk("m_opcode", {59'd0, alu_opcode}, {59'd0, m_op});
      chk("m_ra_rb", {alu_ra, alu_rb}, {m_ra, m_rb});
      chk("m_result", {result_hi, result_lo}, {m_hi, m_lo});
    end
  end

  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); #1;
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc, output int busy);
    bit fin;
    cyc = 0; busy = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (done) fin = 1'b1;
      else begin
        if (!ready) busy++;
        if (cyc > 200) begin
          n_checks++; n_err++;
          $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
          fin = 1'b1;
        end
      end
    end
  endtask

  int  cyc, busy;
  bit  got;

  initial begin
    @(negedge clk);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_outs", {result_hi, result_lo}, 64'd0);
    chk("rst_flags", {61'd0, done, err, div_start}, 64'd0);
    #1 reset = 1'b1;

    // add 5 + 7
    issue(ADD, 32'd5, 32'd7);
    wait_done("add", cyc, busy);
    chk("add_lat", 64'(cyc), 64'd2);
    chk("add_lo", {32'd0, result_lo}, 64'd12);
    chk("add_hi", {32'd0, result_hi}, 64'd0);
    chk("add_err", {63'd0, err}, 64'd0);
    chk("add_opc", {59'd0, alu_opcode}, 64'd0);

    issue(SUB, 32'd5, 32'd7);
    wait_done("sub", cyc, busy);
    chk("sub_lo", {32'd0, result_lo}, 64'hFFFFFFFE);
    issue(MUL, 32'h10000, 32'h10000);
    wait_done("mul", cyc, busy);
    chk("mul_lat", 64'(cyc), 64'd2);
    chk("mul_res", {result_hi, result_lo}, 64'h00000001_00000000);
    issue(SHRA, 32'h80000000, 32'd4);
    wait_done("shra", cyc, busy);
    chk("shra_lo", {32'd0, result_lo}, 64'hF8000000);
    issue(ROL, 32'h80000001, 32'd1);
    wait_done("rol", cyc, busy);
    chk("rol_lo", {32'd0, result_lo}, 64'h3);
    issue(ROR, 32'd1, 32'd1);
    wait_done("ror", cyc, busy);
    chk("ror_lo", {32'd0, result_lo}, 64'h80000000);

    // div 100 / 7 with a stray start pulse during EXEC
    @(negedge clk); #1;
    start = 1'b1; op = DIV; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    busy = 0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (!ready) busy++;
        if (i == 0) chk("div_start_first", {63'd0, div_start}, 64'd1);
        if (i == 1) chk("div_start_second", {63'd0, div_start}, 64'd0);
        if (i == 5) begin #1 start = 1'b1; op = ADD; a_in = 32'd1; b_in = 32'd1; end
        if (i == 6) begin #1 start = 1'b0; end
      end
    end
    chk("div_done_seen", {63'd0, got}, 64'd1);
    chk("div_busy_cycles", 64'(busy), 64'(DIV_LAT));
    chk("div_res", {result_hi, result_lo}, {32'd2, 32'd14});
    chk("div_opc_held", {59'd0, alu_opcode}, {59'd0, DIV});

    // illegal opcode
    issue(BAD, 32'd1, 32'd2);
    wait_done("illegal", cyc, busy);
    chk("ill_lat", 64'(cyc), 64'd1);
    chk("ill_err", {63'd0, err}, 64'd1);
    chk("ill_res", {result_hi, result_lo}, {32'd2, 32'd14});

    // back-to-back: or then and, start held across DONE
    @(negedge clk); #1;
    start = 1'b1; op = OR_; a_in = 32'hF0; b_in = 32'h0F;
    @(posedge clk); #1 op = AND_;
    @(negedge clk);
    chk("b2b_exec1", {63'd0, ready}, 64'd0);
    @(negedge clk);
    chk("b2b_done1", {63'd0, done}, 64'd1);
    chk("b2b_or_lo", {32'd0, result_lo}, 64'hFF);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_no_idle", {63'd0, ready}, 64'd0);
    @(negedge clk);
    chk("b2b_done2", {63'd0, done}, 64'd1);
    chk("b2b_and_lo", {32'd0, result_lo}, 64'h0);
    chk("b2b_err", {63'd0, err}, 64'd0);

    // divide by zero
    issue(DIV, 32'd9, 32'd0);
    wait_done("div0", cyc, busy);
`ifdef ALU_OP_CONTROLLER_DIV0_TRAP_EN
    chk("div0_lat", 64'(cyc), 64'd1);
    chk("div0_err", {63'd0, err}, 64'd1);
    chk("div0_res", {result_hi, result_lo}, 64'd0);
`else
    chk("div0_lat", 64'(cyc), 64'(DIV_LAT + 1));
    chk("div0_err", {63'd0, err}, 64'd0);
    chk("div0_res", {result_hi, result_lo}, {32'd9, 32'hFFFFFFFF});
`endif

    // reset in the middle of a divide
    issue(DIV, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {63'd0, ready}, 64'd1);
    chk("mid_rst_regs", {27'd0, alu_opcode, alu_ra}, 64'd0);
    chk("mid_rst_rb", {32'd0, alu_rb}, 64'd0);
    chk("mid_rst_res", {result_hi, result_lo}, 64'd0);
    chk("mid_rst_flags", {61'd0, done, err, div_start}, 64'd0);
    #1 reset = 1'b1;
    got = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("mid_rst_no_done", {63'd0, got}, 64'd0);

    // recovery
    issue(ADD, 32'd3, 32'd4);
    wait_done("recover", cyc, busy);
    chk("recover_lo", {32'd0, result_lo}, 64'd7);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_controller.md
ALU_OP_CONTROLLER -- requirements
Module: alu_op_controller

Interface
REQ-001 The block SHALL have parameter DIV_LATENCY, default 34: number of EXEC cycles for a divide (legal range 1..63).
REQ-002 The block SHALL have parameter MUL_LATENCY, default 1: number of EXEC cycles for a multiply (legal range 1..63).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request strobe; sampled only when ready=1.
REQ-006 op  input  5  requested opcode, ALU encoding: add 00000, sub 00001, mul 00010, div 00011, and 00100, or 00101, shr 00110, shra 00111, shl 01000, ror 01001, rol 01011, neg 01100, not 01101.
REQ-007 a_in, b_in  input  32 each  operands.
REQ-008 ready  output  1  high in IDLE or DONE; request may be accepted.
REQ-009 alu_opcode  output  5  registered opcode driven to ALU.
REQ-010 alu_ra, alu_rb  output  32 each  registered operands driven to ALU.
REQ-011 div_start  output  1  one-cycle pulse restarting the divider.
REQ-012 alu_rz  input  64  ALU result.
REQ-013 result_lo, result_hi  output  32 each  captured alu_rz[31:0] and alu_rz[63:32].
REQ-014 done  output  1  one-cycle pulse; results valid.
REQ-015 err  output  1  valid with done; request was rejected.

Function
REQ-016 States SHALL be IDLE, EXEC, DONE; a 6-bit down-counter cnt SHALL time EXEC.
REQ-017 Accept = start & ready; on accept, op/a_in/b_in SHALL be registered onto alu_opcode/alu_ra/alu_rb, held stable until the next accept.
REQ-018 On accept of a legal opcode: next state EXEC, cnt loaded with DIV_LATENCY-1 for div, MUL_LATENCY-1 for mul, 0 for all others.
REQ-019 In EXEC, cnt SHALL decrement each cycle; when cnt=0, the edge SHALL capture alu_rz into result_lo/result_hi and move to DONE.
REQ-020 Latency: single-cycle op accepted at edge E0 SHALL have done=1 in the cycle after edge E1; div SHALL have done=1 after edge E0+DIV_LATENCY.
REQ-021 div_start SHALL be 1 exactly during the first EXEC cycle of a div and 0 otherwise.
REQ-022 In DONE, done=1 for one cycle; next state EXEC on accept (back-to-back), else IDLE.
REQ-023 Illegal opcodes (01010, 01110..11111) SHALL go directly to DONE with err=1; result_lo/result_hi SHALL remain unchanged.
REQ-024 start while ready=0 SHALL be ignored, with no effect on state or outputs.
REQ-025 err SHALL be 0 whenever done=0 and on every legal completion.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, cnt=0, and alu_opcode, alu_ra, alu_rb, result_lo, result_hi, done, err, div_start all to 0; ready=1.
REQ-027 reset asserted mid-EXEC SHALL abort the operation with no done pulse after release.

Configuration
REQ-028 With macro ALU_OP_CONTROLLER_DIV0_TRAP_EN defined, div with b_in=0 SHALL go directly to DONE with err=1, no div_start, results unchanged.
REQ-029 Without ALU_OP_CONTROLLER_DIV0_TRAP_EN, div with b_in=0 SHALL run the full DIV_LATENCY and capture alu_rz with err=0.

Verification
REQ-030 Reset, then add a_in=5 b_in=7 -> alu_opcode=00000, done one cycle after edge E1, result_lo=12, result_hi=0, err=0.
REQ-031 div a_in=100 b_in=7, DIV_LATENCY=34 -> div_start pulse first EXEC cycle, ready=0 for 34 cycles, done with result_lo=14; start pulses during EXEC ignored.
REQ-032 op=01010 -> done next cycle with err=1, result_lo/hi unchanged from prior op.
REQ-033 start held high across DONE with or a=F0 b=0F then and a=F0 b=0F -> back-to-back completions, result_lo=FF then 00, no IDLE cycle.
REQ-034 div b_in=0 with macro defined -> err=1 after one cycle; without macro -> full latency, err=0; reset=0 mid-div -> all outputs 0, no done after release.
